// File: rtl/pipeline_sequencer_if.sv
// Pixel stream handshake between an RGB source and the pipeline sequencer.
// The source drives in_valid/in_data; the sequencer answers with in_ready.
interface pipeline_sequencer_if #(
    parameter int PIXEL_SIZE = 24
);
    logic                  in_valid;
    logic                  in_ready;
    logic [PIXEL_SIZE-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/pipeline_sequencer.sv
// Front-end controller for the detection datapath (rgb2i -> sobel -> threshold -> CC).
// Takes a valid/ready RGB pixel stream, drives the datapath en/hsync/vsync/data/mode,
// latches the mode once per frame, and then issues en-only flush cycles so the
// row buffers drain their final rows. Reports busy/done and a completed-frame count.
// Optional build macro PIPELINE_SEQUENCER_CONTINUOUS_EN: when defined, a finished
// frame rolls straight into the next one (mode re-latched) without a start pulse.
module pipeline_sequencer #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int FLUSH_CYCLES = 1284,
    parameter int PIXEL_SIZE   = 24,
    parameter int WORD_SIZE    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    pipeline_sequencer_if.slave   px,
    input  logic [WORD_SIZE-1:0]  mode_in,
    output logic                  en,
    output logic                  hsync,
    output logic                  vsync,
    output logic [PIXEL_SIZE-1:0] pix_out,
    output logic [WORD_SIZE-1:0]  mode_out,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           frame_count
);

    localparam int XW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST    = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(FRAME_HEIGHT - 1);
    localparam logic [15:0]   FLUSH_LEN = 16'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [15:0]   flush_cnt;

    // Frame sequencer: state, position counters and every registered output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            flush_cnt   <= '0;
            px.in_ready <= 1'b0;
            en          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            pix_out     <= '0;
            mode_out    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_count <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; these defaults make en/hsync/vsync/done
            // single-cycle pulses that a later assignment in the same cycle simply overrides.
            en    <= 1'b0;
            hsync <= 1'b0;
            vsync <= 1'b0;
            done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        mode_out    <= mode_in;
                        x           <= '0;
                        y           <= '0;
                        state       <= STREAM;
                        px.in_ready <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                STREAM: begin
                    if (px.in_valid && px.in_ready) begin
                        en      <= 1'b1;
                        pix_out <= px.in_data;
                        hsync   <= (x == '0);
                        vsync   <= (x == '0) && (y == '0);
                        if (x == X_LAST) begin
                            x <= '0;
                            if (y == Y_LAST) begin
                                // Last pixel of the frame: stop accepting and start draining.
                                y           <= '0;
                                flush_cnt   <= FLUSH_LEN;
                                state       <= FLUSH;
                                px.in_ready <= 1'b0;
                            end else begin
                                y <= y + 1'b1;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end

                FLUSH: begin
                    en        <= 1'b1;
                    pix_out   <= '0;
                    flush_cnt <= flush_cnt - 1'b1;
                    if (flush_cnt == 16'd1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end

                DONE: begin
                    done        <= 1'b1;
                    frame_count <= frame_count + 16'd1;
`ifdef PIPELINE_SEQUENCER_CONTINUOUS_EN
                    mode_out    <= mode_in;
                    x           <= '0;
                    y           <= '0;
                    state       <= STREAM;
                    px.in_ready <= 1'b1;
                    busy        <= 1'b1;
`else
                    state       <= IDLE;
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer with a 4x3 frame and 5 flush cycles.
// Expected datapath beats are queued when a pixel is handed over and compared,
// cycle by cycle, against en/pix_out/hsync/vsync/mode_out.
module tb_pipeline_sequencer;

    localparam int FW   = 4;
    localparam int FH   = 3;
    localparam int FC   = 5;
    localparam int NPIX = FW * FH;

    typedef struct {
        int          exp_cyc;
        logic [23:0] pix;
        logic        hs;
        logic        vs;
        logic [7:0]  mode;
        bit          flush;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  mode_in;
    logic        en, hsync, vsync, busy, done;
    logic [23:0] pix_out;
    logic [7:0]  mode_out;
    logic [15:0] frame_count;

    int   errors    = 0;
    int   checks    = 0;
    int   cyc       = 0;
    int   stream_en = 0;
    bit   mon_on    = 1'b0;
    exp_t sb[$];
    exp_t mon_item;

    pipeline_sequencer_if #(.PIXEL_SIZE(24)) px_if ();

    pipeline_sequencer #(
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH),
        .FLUSH_CYCLES(FC),
        .PIXEL_SIZE  (24),
        .WORD_SIZE   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .px         (px_if.slave),
        .mode_in    (mode_in),
        .en         (en),
        .hsync      (hsync),
        .vsync      (vsync),
        .pix_out    (pix_out),
        .mode_out   (mode_out),
        .busy       (busy),
        .done       (done),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: each cycle either the front beat is due or en must be low.
    always @(negedge clk) begin
        if (mon_on) begin
            while (sb.size() > 0 && sb[0].exp_cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_beat: expected beat pix=%0d at cycle %0d never seen", sb[0].pix, sb[0].exp_cyc);
                sb.delete(0);
            end
            checks++;
            if (sb.size() > 0 && sb[0].exp_cyc == cyc) begin
                mon_item = sb.pop_front();
                if ({en, pix_out, hsync, vsync, mode_out} !==
                    {1'b1, mon_item.pix, mon_item.hs, mon_item.vs, mon_item.mode}) begin
                    errors++;
                    $display("FAIL beat cyc=%0d: got en=%b pix=%0d hs=%b vs=%b mode=%h, want en=1 pix=%0d hs=%b vs=%b mode=%h",
                             cyc, en, pix_out, hsync, vsync, mode_out,
                             mon_item.pix, mon_item.hs, mon_item.vs, mon_item.mode);
                end else if (!mon_item.flush) begin
                    stream_en++;
                end
            end else if (en !== 1'b0 || hsync !== 1'b0 || vsync !== 1'b0) begin
                errors++;
                $display("FAIL idle_beat cyc=%0d: got en=%b hs=%b vs=%b, want all 0", cyc, en, hsync, vsync);
            end
        end
    end

    // Starts (optionally) and streams one frame, queuing the pixel and flush beats it should produce.
    task automatic stream_frame(input bit do_start, input logic [7:0] mode, input bit sparse,
                                input int chg_at, input logic [7:0] chg_mode);
        int   k;
        int   t;
        exp_t it;
        k = 0;
        t = 0;
        @(posedge clk); #1;
        if (do_start) begin
            start   = 1'b1;
            mode_in = mode;
            @(posedge clk); #1;
            start = 1'b0;
        end
        while (k < NPIX && t < 400) begin
            if (k == chg_at) mode_in = chg_mode;
            px_if.in_valid = sparse ? (t % 3 == 0) : 1'b1;
            px_if.in_data  = 24'(k + 1);
            if (px_if.in_valid && px_if.in_ready) begin
                it.exp_cyc = cyc + 1;
                it.pix     = 24'(k + 1);
                it.hs      = (k % FW == 0);
                it.vs      = (k == 0);
                it.mode    = mode;
                it.flush   = 1'b0;
                sb.push_back(it);
                if (k == NPIX - 1) begin
                    for (int j = 1; j <= FC; j++) begin
                        it.exp_cyc = cyc + 1 + j;
                        it.pix     = '0;
                        it.hs      = 1'b0;
                        it.vs      = 1'b0;
                        it.flush   = 1'b1;
                        sb.push_back(it);
                    end
                end
                k++;
            end
            t++;
            @(posedge clk); #1;
        end
        px_if.in_valid = 1'b0;
        checks++;
        if (k != NPIX) begin
            errors++;
            $display("FAIL accept_timeout: accepted %0d pixels, want %0d", k, NPIX);
        end
    endtask

    // Waits (bounded) for the done pulse and checks the frame-end status outputs.
    task automatic wait_done(input logic [15:0] exp_fc, input logic exp_active);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL done_timeout: no done pulse within 200 cycles");
        end else begin
            checks++;
            if (frame_count !== exp_fc) begin
                errors++;
                $display("FAIL frame_count: got %0d, want %0d", frame_count, exp_fc);
            end
            checks++;
            if (busy !== exp_active || px_if.in_ready !== exp_active) begin
                errors++;
                $display("FAIL done_status: got busy=%b in_ready=%b, want %b", busy, px_if.in_ready, exp_active);
            end
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL leftover_beats: %0d expected beats not seen, want 0", sb.size());
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_width: done=%b one cycle later, want 0", done);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            start          = 1'($urandom_range(0, 1));
            px_if.in_valid = 1'($urandom_range(0, 1));
            px_if.in_data  = 24'($urandom);
            mode_in        = 8'($urandom);
        end
        @(negedge clk);
        checks++;
        if ({en, px_if.in_ready, busy, done, hsync, vsync, frame_count, pix_out, mode_out} !== '0) begin
            errors++;
            $display("FAIL reset_state: en=%b rdy=%b busy=%b done=%b hs=%b vs=%b fc=%0d pix=%0d mode=%h, want all 0",
                     en, px_if.in_ready, busy, done, hsync, vsync, frame_count, pix_out, mode_out);
        end
        @(posedge clk); #1;
        reset          = 1'b0;
        start          = 1'b0;
        px_if.in_valid = 1'b0;
        px_if.in_data  = '0;
        mode_in        = '0;
        mon_on         = 1'b1;
    endtask

    task automatic test_full_frame();
        int s0;
        s0 = stream_en;
        stream_frame(1'b1, 8'h03, 1'b0, -1, 8'h00);
        wait_done(16'd1, 1'b0);
        checks++;
        if (stream_en - s0 != NPIX) begin
            errors++;
            $display("FAIL full_stream_en: got %0d pixel beats, want %0d", stream_en - s0, NPIX);
        end
    endtask

    task automatic test_sparse_valid();
        int s0;
        s0 = stream_en;
        stream_frame(1'b1, 8'h05, 1'b1, -1, 8'h00);
        wait_done(16'd2, 1'b0);
        checks++;
        if (stream_en - s0 != NPIX) begin
            errors++;
            $display("FAIL sparse_stream_en: got %0d pixel beats, want %0d", stream_en - s0, NPIX);
        end
    endtask

    task automatic test_mode_latch();
        stream_frame(1'b1, 8'h01, 1'b0, 6, 8'h04);
        wait_done(16'd3, 1'b0);
        checks++;
        if (mode_out !== 8'h01) begin
            errors++;
            $display("FAIL mode_hold: got %h, want 01", mode_out);
        end
        stream_frame(1'b1, 8'h04, 1'b0, -1, 8'h00);
        wait_done(16'd4, 1'b0);
    endtask

    task automatic test_reset_in_flush();
        stream_frame(1'b1, 8'h07, 1'b0, -1, 8'h00);
        // Now in the first FLUSH cycle; move to the third and reset there.
        @(posedge clk); #1;
        @(posedge clk); #1;
        mon_on = 1'b0;
        reset  = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({en, px_if.in_ready, busy, done, frame_count} !== '0) begin
            errors++;
            $display("FAIL flush_reset: en=%b rdy=%b busy=%b done=%b fc=%0d, want all 0",
                     en, px_if.in_ready, busy, done, frame_count);
        end
        sb.delete();
        mon_on = 1'b1;
        stream_frame(1'b1, 8'h09, 1'b0, -1, 8'h00);
        wait_done(16'd1, 1'b0);
    endtask

    task automatic test_continuous();
        stream_frame(1'b1, 8'h02, 1'b0, -1, 8'h00);
        wait_done(16'd1, 1'b1);
        stream_frame(1'b0, 8'h02, 1'b0, -1, 8'h00);
        wait_done(16'd2, 1'b1);
        stream_frame(1'b0, 8'h02, 1'b0, -1, 8'h00);
        wait_done(16'd3, 1'b1);
    endtask

    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        mode_in        = '0;
        px_if.in_valid = 1'b0;
        px_if.in_data  = '0;
        test_reset();
`ifdef PIPELINE_SEQUENCER_CONTINUOUS_EN
        test_continuous();
`else
        test_full_frame();
        test_sparse_valid();
        test_mode_latch();
        test_reset_in_flush();
`endif
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
